// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: parallel-side and line-side signals of the configurable UART transmitter.
`default_nettype none
`timescale 1ns/1ps

interface uart_tx_cfg_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      DATA_VALID;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic                      STOP2;
  logic [PRESCALE_WIDTH-1:0] PRESCALE;
  logic                      TX_OUT;
  logic                      BUSY;
  logic                      TX_DONE;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2, PRESCALE,
    input  TX_OUT, BUSY, TX_DONE
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2, PRESCALE,
    output TX_OUT, BUSY, TX_DONE
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with configurable width, parity, stop bits and per-bit prescale.
// Rev 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module uart_tx_cfg #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic          CLK,
  input  logic          RST,
  uart_tx_cfg_if.slave  bus
);

  generate
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_width_check
      $error("uart_tx_cfg: DATA_WIDTH must be in 5..9");
    end
  endgenerate

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0]          LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]          BIT_ONE  = BIT_W'(1);
  localparam logic [PRESCALE_WIDTH-1:0] PS_ONE   = PRESCALE_WIDTH'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]                state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] per_q, per_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [DATA_WIDTH-1:0]     sh_q, sh_d;
  logic                      par_en_q, par_en_d;
  logic                      par_q, par_d;
  logic                      stop2_q, stop2_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      load;
  logic                      bit_end;

  assign bit_end = (cnt_q == per_q - PS_ONE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    stop2_d  = stop2_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.DATA_VALID) load = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = sh_q[0];
        end else begin
          cnt_d = cnt_q + PS_ONE;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            // sh_q[0] is always the bit currently on the line
            bit_d = bit_q + BIT_ONE;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end else begin
          cnt_d = cnt_q + PS_ONE;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + PS_ONE;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stop2_q && bit_q == '0) begin
            bit_d = BIT_ONE;
          end else begin
            done_d = 1'b1;
            bit_d  = '0;
            if (bus.DATA_VALID) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + PS_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Frame configuration is captured only here and held until the next accept
    if (load) begin
      state_d  = S_START;
      cnt_d    = '0;
      bit_d    = '0;
      sh_d     = bus.P_DATA;
      par_en_d = bus.PAR_EN;
      par_d    = (^bus.P_DATA) ^ bus.PAR_TYP;
      stop2_d  = bus.STOP2;
      per_d    = (bus.PRESCALE == '0) ? PS_ONE : bus.PRESCALE;
      tx_d     = 1'b0;
      busy_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      per_q    <= PS_ONE;
      bit_q    <= '0;
      sh_q     <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      stop2_q  <= stop2_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.TX_OUT  = tx_q;
  assign bus.BUSY    = busy_q;
  assign bus.TX_DONE = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboard bench; each accepted frame pushes its per-cycle line/BUSY/TX_DONE image.
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_cfg;
  localparam int DW = 8;
  localparam int PW = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) bus ();

  uart_tx_cfg #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) u_dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  logic [2:0] exp_q[$];

  logic [DW-1:0] f_d;
  logic          f_pe, f_pt, f_s2;
  logic [PW-1:0] f_ps;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply(input logic [DW-1:0] d, input logic pe, input logic pt,
                       input logic s2, input logic [PW-1:0] ps);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.STOP2      = s2;
    bus.PRESCALE   = ps;
    bus.DATA_VALID = 1'b1;
    f_d = d; f_pe = pe; f_pt = pt; f_s2 = s2; f_ps = ps;
  endtask

  task automatic push_bit(input logic b, input int p, input bit done_first);
    for (int k = 0; k < p; k++)
      exp_q.push_back({b, 1'b1, (k == 0) && done_first});
  endtask

  // Waits for the accepting edge, then queues the expected {TX_OUT,BUSY,TX_DONE} per cycle
  task automatic accept(input bit done_first, input bit done_last);
    int p;
    @(posedge clk);
    #1 bus.DATA_VALID = 1'b0;
    p = (f_ps == '0) ? 1 : int'(f_ps);
    push_bit(1'b0, p, done_first);
    for (int i = 0; i < DW; i++) push_bit(f_d[i], p, 1'b0);
    if (f_pe) push_bit((^f_d) ^ f_pt, p, 1'b0);
    push_bit(1'b1, p, 1'b0);
    if (f_s2) push_bit(1'b1, p, 1'b0);
    if (done_last) exp_q.push_back(3'b101);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    logic [2:0] e;
    if (mon_en) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b100;
      check_eq("line", {bus.TX_OUT, bus.BUSY, bus.TX_DONE}, e);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.P_DATA = '0; bus.DATA_VALID = 1'b0; bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0; bus.STOP2 = 1'b0; bus.PRESCALE = PW'(1);

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_tx",   bus.TX_OUT,  1);
    check_eq("rst_busy", bus.BUSY,    0);
    check_eq("rst_done", bus.TX_DONE, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 8N1 basic
    apply(8'hA5, 1'b0, 1'b0, 1'b0, PW'(1)); accept(1'b0, 1'b1); wait_drain();
    // parity variants
    apply(8'hA5, 1'b1, 1'b0, 1'b0, PW'(1)); accept(1'b0, 1'b1); wait_drain();
    apply(8'hA5, 1'b1, 1'b1, 1'b0, PW'(1)); accept(1'b0, 1'b1); wait_drain();
    apply(8'h01, 1'b1, 1'b0, 1'b0, PW'(1)); accept(1'b0, 1'b1); wait_drain();
    // prescale 4, two stop bits
    apply(8'h3C, 1'b0, 1'b0, 1'b1, PW'(4)); accept(1'b0, 1'b1); wait_drain();
    // prescale 0 behaves as 1
    apply(8'h96, 1'b1, 1'b0, 1'b1, PW'(0)); accept(1'b0, 1'b1); wait_drain();

    // mid-frame request ignored, then back-to-back at the final stop edge
    apply(8'hA5, 1'b0, 1'b0, 1'b0, PW'(1)); accept(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 bus.P_DATA = 8'hFF; bus.DATA_VALID = 1'b1;
    @(posedge clk);
    #1 bus.DATA_VALID = 1'b0;
    repeat (5) @(posedge clk);
    #1 apply(8'h00, 1'b0, 1'b0, 1'b0, PW'(1));
    accept(1'b1, 1'b1); wait_drain();

    // config changed mid-frame only takes effect on the next frame
    apply(8'h5A, 1'b0, 1'b0, 1'b0, PW'(2)); accept(1'b0, 1'b1);
    repeat (6) @(posedge clk);
    #1 bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b1; bus.PRESCALE = PW'(3); bus.P_DATA = 8'hC3;
    wait_drain();
    apply(8'hC3, 1'b1, 1'b1, 1'b0, PW'(3)); accept(1'b0, 1'b1); wait_drain();

    // asynchronous reset during data bit 3
    apply(8'hA5, 1'b0, 1'b0, 1'b0, PW'(4)); accept(1'b0, 1'b1);
    repeat (17) @(posedge clk);
    #2;
    mon_en = 1'b0;
    exp_q.delete();
    check_eq("pre_rst_tx", bus.TX_OUT, 0);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_tx",   bus.TX_OUT,  1);
    check_eq("async_rst_busy", bus.BUSY,    0);
    check_eq("async_rst_done", bus.TX_DONE, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    apply(8'h0F, 1'b0, 1'b0, 1'b1, PW'(1)); accept(1'b0, 1'b1); wait_drain();

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
